rgb_hue_sequencer: RTL and testbench

//  Parametrised successor to the fixed-rate RGB colour cycler: drives the active-low on-board RGB LED

---
 rtl/rgb_hue_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_rgb_hue_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_hue_sequencer.sv
// Six-colour hue wheel (R>Y>G>C>B>M) for an active-low RGB LED, with hard steps
// or PWM cross-fade, run-time direction, pause and global brightness scaling.
module rgb_hue_sequencer #(
   parameter int STEP_CYCLES = 2_000_000,
   parameter int PWM_BITS    = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_enable,
   input  logic                i_mode,
   input  logic                i_dir,
   input  logic [PWM_BITS-1:0] i_brightness,
   output logic                RGB_R,
   output logic                RGB_G,
   output logic                RGB_B,
   output logic [2:0]          o_segment,
   output logic                o_wrap
);

   localparam int PW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PW-1:0]       PRESC_LAST = PW'(STEP_CYCLES - 1);
   localparam logic [PW-1:0]       PRESC_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0]       PRESC_ONE  = PW'(1);
   localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] ZERO = {PWM_BITS{1'b0}};
   localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

   function automatic logic [2:0] seg_inc(input logic [2:0] seg);
      if (seg >= 3'd5) begin
         return 3'd0;
      end else begin
         return seg + 3'd1;
      end
   endfunction

   // Out-of-range codes also land on 5 so the segment can never stick at 6/7.
   function automatic logic [2:0] seg_dec(input logic [2:0] seg);
      if ((seg == 3'd0) || (seg > 3'd5)) begin
         return 3'd5;
      end else begin
         return seg - 3'd1;
      end
   endfunction

   // eff = comp * (bright + 1) >> PWM_BITS; the product cannot exceed 2*PWM_BITS bits.
   function automatic logic [PWM_BITS-1:0] scale_level(input logic [PWM_BITS-1:0] comp,
                                                      input logic [PWM_BITS-1:0] bright);
      logic [2*PWM_BITS:0] prod;
      prod = {{(PWM_BITS+1){1'b0}}, comp} * {{PWM_BITS{1'b0}}, ({1'b0, bright} + {{PWM_BITS{1'b0}}, 1'b1})};
      return PWM_BITS'(prod >> PWM_BITS);
   endfunction

   logic [PW-1:0]       presc_r, presc_nxt_s;
   logic [2:0]          segment_r, segment_nxt_s;
   logic [PWM_BITS-1:0] level_r, level_nxt_s;
   logic                mode_r, mode_nxt_s;
   logic                wrap_r, wrap_nxt_s;
   logic                tick_s;
   logic [PWM_BITS-1:0] level_inv_s;
   logic [PWM_BITS-1:0] comp_r_s, comp_g_s, comp_b_s;
   logic [2:0][PWM_BITS-1:0] eff_s;
   logic [PWM_BITS-1:0] pwm_cnt_r;
   logic [2:0][PWM_BITS-1:0] duty_r;
   logic [2:0]          lit_s;
   logic [2:0]          pin_r;

   // Prescaler and wheel position next-state; mode/dir only matter on a tick.
   always_comb begin
      tick_s        = i_enable && (presc_r == PRESC_LAST);
      presc_nxt_s   = presc_r;
      segment_nxt_s = segment_r;
      level_nxt_s   = level_r;
      mode_nxt_s    = mode_r;
      wrap_nxt_s    = 1'b0;
      if (tick_s) begin
         presc_nxt_s = PRESC_ZERO;
         mode_nxt_s  = i_mode;
         if (!i_mode) begin
            level_nxt_s = ZERO;
            if (!i_dir) begin
               segment_nxt_s = seg_inc(segment_r);
               wrap_nxt_s    = (segment_r == 3'd5);
            end else begin
               segment_nxt_s = seg_dec(segment_r);
               wrap_nxt_s    = (segment_r == 3'd0);
            end
         end else if (!i_dir) begin
            if (level_r == MAX) begin
               level_nxt_s   = ZERO;
               segment_nxt_s = seg_inc(segment_r);
               wrap_nxt_s    = (segment_r == 3'd5);
            end else begin
               level_nxt_s = level_r + ONE;
            end
         end else begin
            if (level_r == ZERO) begin
               level_nxt_s   = MAX;
               segment_nxt_s = seg_dec(segment_r);
               wrap_nxt_s    = (segment_r == 3'd0);
            end else begin
               level_nxt_s = level_r - ONE;
            end
         end
      end else if (i_enable) begin
         presc_nxt_s = presc_r + PRESC_ONE;
      end else begin
         presc_nxt_s = presc_r;
      end
   end

   // Position state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_r   <= PRESC_ZERO;
         segment_r <= 3'd0;
         level_r   <= ZERO;
         mode_r    <= 1'b0;
         wrap_r    <= 1'b0;
      end else begin
         presc_r   <= presc_nxt_s;
         segment_r <= segment_nxt_s;
         level_r   <= level_nxt_s;
         mode_r    <= mode_nxt_s;
         wrap_r    <= wrap_nxt_s;
      end
   end

   // Colour-wheel component levels; in step mode the level is zero, the table just states it outright.
   always_comb begin
      level_inv_s = MAX - level_r;
      comp_r_s    = ZERO;
      comp_g_s    = ZERO;
      comp_b_s    = ZERO;
      case (segment_r)
         3'd0: begin
            comp_r_s = MAX;
            comp_g_s = mode_r ? level_r : ZERO;
            comp_b_s = ZERO;
         end
         3'd1: begin
            comp_r_s = mode_r ? level_inv_s : MAX;
            comp_g_s = MAX;
            comp_b_s = ZERO;
         end
         3'd2: begin
            comp_r_s = ZERO;
            comp_g_s = MAX;
            comp_b_s = mode_r ? level_r : ZERO;
         end
         3'd3: begin
            comp_r_s = ZERO;
            comp_g_s = mode_r ? level_inv_s : MAX;
            comp_b_s = MAX;
         end
         3'd4: begin
            comp_r_s = mode_r ? level_r : ZERO;
            comp_g_s = ZERO;
            comp_b_s = MAX;
         end
         3'd5: begin
            comp_r_s = MAX;
            comp_g_s = ZERO;
            comp_b_s = mode_r ? level_inv_s : MAX;
         end
         default: begin
            comp_r_s = ZERO;
            comp_g_s = ZERO;
            comp_b_s = ZERO;
         end
      endcase
      eff_s[0] = scale_level(comp_r_s, i_brightness);
      eff_s[1] = scale_level(comp_g_s, i_brightness);
      eff_s[2] = scale_level(comp_b_s, i_brightness);
      for (int i = 0; i < 3; i++) begin
         lit_s[i] = (pwm_cnt_r < duty_r[i]);
      end
   end

   // PWM counter, period-aligned duty reload and registered active-low pins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt_r <= ZERO;
         duty_r    <= {3{ZERO}};
         pin_r     <= 3'b111;
      end else begin
         pwm_cnt_r <= pwm_cnt_r + ONE;
         if (pwm_cnt_r == MAX) begin
            duty_r <= eff_s;
         end
         pin_r <= ~lit_s;
      end
   end

   assign RGB_R     = pin_r[0];
   assign RGB_G     = pin_r[1];
   assign RGB_B     = pin_r[2];
   assign o_segment = segment_r;
   assign o_wrap    = wrap_r;

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// Directed bench for rgb_hue_sequencer with STEP_CYCLES=4, PWM_BITS=4:
// a vector table of wheel positions plus hand-written wrap, pause and reset sequences.
module tb_rgb_hue_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_enable;
   logic       i_mode;
   logic       i_dir;
   logic [3:0] i_brightness;
   logic       RGB_R, RGB_G, RGB_B;
   logic [2:0] o_segment;
   logic       o_wrap;

   int n_vec = 0;
   int n_err = 0;

   rgb_hue_sequencer #(.STEP_CYCLES(4), .PWM_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_mode(i_mode), .i_dir(i_dir),
      .i_brightness(i_brightness), .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
      .o_segment(o_segment), .o_wrap(o_wrap)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mode;
      logic       dir;
      logic [3:0] bright;
      logic [7:0] ticks;
      logic [2:0] seg;
      logic [4:0] r;
      logic [4:0] g;
      logic [4:0] b;
   } vec_t;

   vec_t tbl [17];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock; inputs are driven and outputs sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Number of lit (low) cycles per pin over one 16-cycle PWM period.
   task automatic measure(output int r, output int g, output int b);
      r = 0; g = 0; b = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (RGB_R == 1'b0) r++;
         if (RGB_G == 1'b0) g++;
         if (RGB_B == 1'b0) b++;
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      i_enable = 1'b1;
      run(n);
      rst_n = 1'b1;
      i_enable = 1'b0;
   endtask

   initial begin
      int r, g, b, bad;
      rst_n = 1'b0; i_enable = 1'b0; i_mode = 1'b0; i_dir = 1'b0; i_brightness = 4'd15;

      //            mode  dir   bright ticks  seg   R      G      B
      tbl[0]  = '{1'b0, 1'b0, 4'd15, 8'd0, 3'd0, 5'd15, 5'd0,  5'd0};
      tbl[1]  = '{1'b0, 1'b0, 4'd15, 8'd1, 3'd1, 5'd15, 5'd15, 5'd0};
      tbl[2]  = '{1'b0, 1'b0, 4'd15, 8'd1, 3'd2, 5'd0,  5'd15, 5'd0};
      tbl[3]  = '{1'b0, 1'b0, 4'd15, 8'd1, 3'd3, 5'd0,  5'd15, 5'd15};
      tbl[4]  = '{1'b0, 1'b0, 4'd15, 8'd1, 3'd4, 5'd0,  5'd0,  5'd15};
      tbl[5]  = '{1'b0, 1'b0, 4'd15, 8'd1, 3'd5, 5'd15, 5'd0,  5'd15};
      tbl[6]  = '{1'b0, 1'b0, 4'd15, 8'd1, 3'd0, 5'd15, 5'd0,  5'd0};
      tbl[7]  = '{1'b0, 1'b1, 4'd15, 8'd1, 3'd5, 5'd15, 5'd0,  5'd15};
      tbl[8]  = '{1'b0, 1'b1, 4'd15, 8'd1, 3'd4, 5'd0,  5'd0,  5'd15};
      tbl[9]  = '{1'b0, 1'b0, 4'd15, 8'd2, 3'd0, 5'd15, 5'd0,  5'd0};
      tbl[10] = '{1'b1, 1'b0, 4'd15, 8'd8, 3'd0, 5'd15, 5'd8,  5'd0};
      tbl[11] = '{1'b1, 1'b0, 4'd15, 8'd8, 3'd1, 5'd15, 5'd15, 5'd0};
      tbl[12] = '{1'b1, 1'b0, 4'd15, 8'd4, 3'd1, 5'd11, 5'd15, 5'd0};
      tbl[13] = '{1'b1, 1'b1, 4'd15, 8'd5, 3'd0, 5'd15, 5'd15, 5'd0};
      tbl[14] = '{1'b1, 1'b1, 4'd15, 8'd3, 3'd0, 5'd15, 5'd12, 5'd0};
      tbl[15] = '{1'b1, 1'b1, 4'd7,  8'd0, 3'd0, 5'd7,  5'd6,  5'd0};
      tbl[16] = '{1'b1, 1'b1, 4'd0,  8'd0, 3'd0, 5'd0,  5'd0,  5'd0};

      // Reset held 3 clocks with enable high, then the first PWM period is dark.
      do_reset(3);
      check("reset_seg", o_segment, 0);
      check("reset_wrap", o_wrap, 0);
      check("reset_pins", {RGB_R, RGB_G, RGB_B}, 3'b111);
      measure(r, g, b);
      check("first_period_r", r, 0);
      check("first_period_gb", g + b, 0);
      measure(r, g, b);
      check("after_reset_r", r, 15);
      check("after_reset_g", g, 0);
      check("after_reset_b", b, 0);

      // Step forward around the whole wheel: one wrap pulse, on the 5->0 tick only.
      i_mode = 1'b0; i_dir = 1'b0; i_enable = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         step();
         check($sformatf("walk_seg_%0d", k), o_segment, (k / 4) % 6);
         check($sformatf("walk_wrap_%0d", k), o_wrap, (k == 24) ? 1 : 0);
      end
      i_enable = 1'b0;

      for (int v = 0; v < 17; v++) begin
         i_mode = tbl[v].mode; i_dir = tbl[v].dir; i_brightness = tbl[v].bright;
         i_enable = 1'b1;
         run(4 * int'(tbl[v].ticks));
         i_enable = 1'b0;
         run(32);
         measure(r, g, b);
         check($sformatf("v%0d_seg", v), o_segment, int'(tbl[v].seg));
         check($sformatf("v%0d_wrap", v), o_wrap, 0);
         check($sformatf("v%0d_r", v), r, int'(tbl[v].r));
         check($sformatf("v%0d_g", v), g, int'(tbl[v].g));
         check($sformatf("v%0d_b", v), b, int'(tbl[v].b));
      end

      // Fade reverse from seg0/level0 wraps to seg5/level15 with a single pulse.
      i_brightness = 4'd15;
      do_reset(2);
      i_mode = 1'b1; i_dir = 1'b1; i_enable = 1'b1;
      run(4);
      i_enable = 1'b0;
      check("rev_wrap_seg", o_segment, 5);
      check("rev_wrap_pulse", o_wrap, 1);
      step();
      check("rev_wrap_clear", o_wrap, 0);
      run(32);
      measure(r, g, b);
      check("rev_seg5_r", r, 15);
      check("rev_seg5_g", g, 0);
      check("rev_seg5_b", b, 0);

      // Pause mid-prescale: position frozen, PWM keeps running, prescaler resumes where it stopped.
      i_dir = 1'b0; i_enable = 1'b1;
      run(2);
      i_enable = 1'b0;
      bad = 0; r = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (o_segment != 3'd5) bad++;
         if ((i < 16) && (RGB_R == 1'b0)) r++;
      end
      check("pause_seg_held", bad, 0);
      check("pause_pwm_r", r, 15);
      i_enable = 1'b1;
      step();
      check("resume_no_tick", o_segment, 5);
      step();
      i_enable = 1'b0;
      check("resume_tick_seg", o_segment, 0);
      check("resume_tick_wrap", o_wrap, 1);

      // Reset in the middle of a fade at seg3/level9.
      do_reset(2);
      i_mode = 1'b1; i_dir = 1'b0; i_enable = 1'b1;
      run(4 * 57);
      i_enable = 1'b0;
      run(32);
      measure(r, g, b);
      check("mid_seg", o_segment, 3);
      check("mid_r", r, 0);
      check("mid_g", g, 6);
      check("mid_b", b, 15);
      rst_n = 1'b0; i_enable = 1'b1;
      step();
      rst_n = 1'b1; i_enable = 1'b0;
      check("midrst_seg", o_segment, 0);
      check("midrst_wrap", o_wrap, 0);
      check("midrst_pins", {RGB_R, RGB_G, RGB_B}, 3'b111);
      measure(r, g, b);
      check("midrst_dark_period", r + g + b, 0);
      measure(r, g, b);
      check("midrst_r", r, 15);
      check("midrst_g", g, 0);
      check("midrst_b", b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
